// File: rtl/gf180mcu_osu_sc_gp12t3v3__nand2_bist_ctrl.sv
// BIST sequencer for one NAND2 cell: walks {A,B} through Gray-ordered vectors,
// samples Y after a settle window and accumulates a saturating error count and failure mask.
module gf180mcu_osu_sc_gp12t3v3__nand2_bist_ctrl #(
  parameter int SETTLE = 2,
  parameter int LOOPS  = 4,
  parameter int ERR_W  = 8
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             START,
  input  logic             ABORT,
  input  logic             Y_DUT,
  output logic             A_DUT,
  output logic             B_DUT,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic [3:0]       FAIL_VEC
);

  localparam int LW = $clog2(LOOPS + 1);
  localparam logic [7:0]    SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [LW-1:0] LOOP_LAST   = LW'(LOOPS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_t;

  state_t            state, state_nxt;
  logic [1:0]        idx, idx_nxt;
  logic [LW-1:0]     loop, loop_nxt;
  logic [7:0]        scnt, scnt_nxt;
  logic [ERR_W-1:0]  err_nxt;
  logic [3:0]        fvec_nxt;
  logic [1:0]        ab_nxt;
  logic              busy_nxt, done_nxt, pass_nxt;
  logic              exp_y;

  // Gray order 00, 01, 11, 10: only one cell input toggles per step
  function automatic logic [1:0] gray_vec(input logic [1:0] i);
    return {i[1], i[1] ^ i[0]};
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    loop_nxt  = loop;
    scnt_nxt  = scnt;
    err_nxt   = ERR_CNT;
    fvec_nxt  = FAIL_VEC;
    exp_y     = ~(&gray_vec(idx));

    case (state)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          state_nxt = ST_SETTLE;
          idx_nxt   = '0;
          loop_nxt  = '0;
          scnt_nxt  = '0;
          err_nxt   = '0;
          fvec_nxt  = '0;
        end
      end
      ST_SETTLE: begin
        if (scnt == SETTLE_LAST) begin
          state_nxt = ST_SAMPLE;
        end else begin
          scnt_nxt = scnt + 8'd1;
        end
      end
      ST_SAMPLE: begin
        if (Y_DUT != exp_y) begin
          err_nxt       = sat_inc(ERR_CNT);
          fvec_nxt[idx] = 1'b1;
        end
        scnt_nxt = '0;
        if (idx != 2'd3) begin
          idx_nxt   = idx + 2'd1;
          state_nxt = ST_SETTLE;
        end else if (loop < LOOP_LAST) begin
          idx_nxt   = '0;
          loop_nxt  = loop + LW'(1);
          state_nxt = ST_SETTLE;
        end else begin
          state_nxt = ST_DONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Abort wins over everything, including a sample landing on this edge
    if (ABORT) begin
      state_nxt = ST_IDLE;
      err_nxt   = ERR_CNT;
      fvec_nxt  = FAIL_VEC;
    end

    busy_nxt = (state_nxt == ST_SETTLE) || (state_nxt == ST_SAMPLE);
    done_nxt = (state_nxt == ST_DONE);
    pass_nxt = done_nxt && (err_nxt == '0);
    ab_nxt   = busy_nxt ? gray_vec(idx_nxt) : 2'b00;
  end

  // Output register stage: every port is driven from a flop
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state    <= ST_IDLE;
      idx      <= '0;
      loop     <= '0;
      scnt     <= '0;
      A_DUT    <= 1'b0;
      B_DUT    <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      PASS     <= 1'b0;
      ERR_CNT  <= '0;
      FAIL_VEC <= '0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      loop     <= loop_nxt;
      scnt     <= scnt_nxt;
      A_DUT    <= ab_nxt[1];
      B_DUT    <= ab_nxt[0];
      BUSY     <= busy_nxt;
      DONE     <= done_nxt;
      PASS     <= pass_nxt;
      ERR_CNT  <= err_nxt;
      FAIL_VEC <= fvec_nxt;
    end
  end

endmodule
